// File: rtl/cnn_arb_pkg.sv
// Shared types and defaults for the CNN job arbiter: FSM state encoding,
// default sizing and the requester-index width helper.
package cnn_arb_pkg;

  localparam int unsigned DEF_NUM_REQ   = 4;
  localparam int unsigned DEF_OUT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_RESP  = 2'd2,
    ST_DRAIN = 2'd3
  } arb_state_e;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_job_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping from NUM_REQ-1 to 0. Returns a one-hot grant and its index.
module rr_arbiter
  import cnn_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = DEF_NUM_REQ,
  localparam int unsigned ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    index
);

  int unsigned     sum;
  logic [ID_W-1:0] cidx;

  // ptr is always < NUM_REQ, so a single conditional subtract wraps the search.
  always_comb begin
    grant = '0;
    index = '0;
    sum   = 0;
    cidx  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sum  = 32'(ptr) + k;
      cidx = (sum >= NUM_REQ) ? ID_W'(sum - NUM_REQ) : ID_W'(sum);
      if ((grant == '0) && req[cidx]) begin
        grant[cidx] = 1'b1;
        index       = cidx;
      end
    end
  end

endmodule

// File: rtl/cnn_job_arbiter.sv
// Shares one CNN core among NUM_REQ requesters: IDLE -> RUN -> RESP -> DRAIN.
// Optional RUN watchdog enabled by defining CNN_ARB_TIMEOUT_EN.
module cnn_job_arbiter
  import cnn_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter  int unsigned OUT_WIDTH      = DEF_OUT_WIDTH,
  parameter  int unsigned TIMEOUT_CYCLES = 2048,
  localparam int unsigned ID_W           = id_width(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 core_enable,
  input  logic                 core_done,
  input  logic [OUT_WIDTH-1:0] core_value,
  output logic                 resp_valid,
  output logic [ID_W-1:0]      resp_id,
  output logic [OUT_WIDTH-1:0] resp_value,
  output logic                 resp_timeout,
  output logic                 busy
);

  if ((NUM_REQ < 2) || (NUM_REQ > 8)) begin : g_bad_num_req
    $error("cnn_job_arbiter: NUM_REQ must be in 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cnn_job_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  arb_state_e             state_q;
  logic [NUM_REQ-1:0]     grant_q;
  logic                   en_q;
  logic [ID_W-1:0]        win_q;
  logic [ID_W-1:0]        ptr_q, ptr_d;
  logic                   rvalid_q;
  logic [ID_W-1:0]        rid_q;
  logic [OUT_WIDTH-1:0]   rval_q;
  logic                   busy_q;

  logic [NUM_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]        arb_idx;
  logic                   arb_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .index (arb_idx)
  );

  assign arb_valid = |arb_grant;
  assign ptr_d     = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);

`ifdef CNN_ARB_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMR_W-1:0] tmr_q;
  logic             rtmo_q;
  assign resp_timeout = rtmo_q;
`else
  assign resp_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      en_q     <= 1'b0;
      win_q    <= '0;
      ptr_q    <= '0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rval_q   <= '0;
      busy_q   <= 1'b0;
`ifdef CNN_ARB_TIMEOUT_EN
      tmr_q    <= '0;
      rtmo_q   <= 1'b0;
`endif
    end else begin
      rvalid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (arb_valid) begin
            state_q <= ST_RUN;
            grant_q <= arb_grant;
            win_q   <= arb_idx;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
`ifdef CNN_ARB_TIMEOUT_EN
            tmr_q   <= '0;
`endif
          end
        end
        ST_RUN: begin
          // core_done wins over the watchdog when both land on the same cycle.
          if (core_done) begin
            state_q  <= ST_RESP;
            en_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rid_q    <= win_q;
            rval_q   <= core_value;
`ifdef CNN_ARB_TIMEOUT_EN
            rtmo_q   <= 1'b0;
          end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            state_q  <= ST_RESP;
            en_q     <= 1'b0;
            rvalid_q <= 1'b1;
            rid_q    <= win_q;
            rval_q   <= '0;
            rtmo_q   <= 1'b1;
          end else begin
            tmr_q    <= tmr_q + TMR_W'(1);
`endif
          end
        end
        ST_RESP: begin
          state_q <= ST_DRAIN;
          grant_q <= '0;
          ptr_q   <= ptr_d;
        end
        ST_DRAIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign core_enable = en_q;
  assign resp_valid  = rvalid_q;
  assign resp_id     = rid_q;
  assign resp_value  = rval_q;
  assign busy        = busy_q;

endmodule
